// File: rtl/dice_pool_roller.sv
// Purpose : rolls a pool of 1..MAX_DICE dice with 2..2^SIDES_W-1 sides each. Draws come from a
//           seedable 16-bit Galois LFSR, and rejection sampling keeps every face equally likely.
// Latency : trigger-to-done is n+1 cycles, plus one cycle per rejected draw; outputs are registered.
// Backpressure: none. A rising edge on roll is honoured only in IDLE; edges during DRAW/DONE are dropped.
// Ports   : clk/rst (sync, active-high); seed_load/seed reload the LFSR; roll/num_dice/num_sides start a roll;
//           busy (DRAW), die_valid/die_value (per accepted die), sum (running total), done, error (bad config).
module dice_pool_roller #(
    parameter int unsigned  MAX_DICE = 8,
    parameter int unsigned  SIDES_W  = 8,
    parameter logic [15:0]  SEED     = 16'hACE1,
    localparam int unsigned CNT_W    = $clog2(MAX_DICE + 1),
    localparam int unsigned SUM_W    = SIDES_W + CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    input  logic               roll,
    input  logic [CNT_W-1:0]   num_dice,
    input  logic [SIDES_W-1:0] num_sides,
    output logic               busy,
    output logic               die_valid,
    output logic [SIDES_W-1:0] die_value,
    output logic [SUM_W-1:0]   sum,
    output logic               done,
    output logic               error
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_DICE);

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_adv;
    logic               roll_prev_q, roll_prev_d;
    logic [CNT_W-1:0]   n_q, n_d, cnt_q, cnt_d;
    logic [SIDES_W-1:0] s_q, s_d, mask_q, mask_d;
    logic [SIDES_W-1:0] die_value_q, die_value_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               busy_q, busy_d;
    logic               die_valid_q, die_valid_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               trig;
    logic               cfg_ok;
    logic               accept;
    logic [SIDES_W-1:0] cand;
    logic [SIDES_W-1:0] mask_calc;

    // Galois right-shift, taps for x^16+x^14+x^13+x^11+1
    assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    assign trig   = roll && !roll_prev_q;
    assign cfg_ok = (num_dice != '0) && (num_dice <= MAX_N) && (num_sides >= SIDES_W'(2));

    // Smear the top set bit of s-1 downward to get the smallest all-ones mask covering s-1
    always_comb begin
        mask_calc = num_sides - SIDES_W'(1);
        for (int i = 1; i < SIDES_W; i++) begin
            mask_calc = mask_calc | (mask_calc >> i);
        end
    end

    assign cand   = lfsr_q[SIDES_W-1:0] & mask_q;
    assign accept = (state_q == ST_DRAW) && (cand < s_q);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_adv;
        roll_prev_d = roll;
        n_d         = n_q;
        s_d         = s_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        die_value_d = die_value_q;
        die_valid_d = 1'b0;
        error_d     = 1'b0;

        // A reload replaces this cycle's advance; zero would lock the LFSR up
        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    if (cfg_ok) begin
                        n_d     = num_dice;
                        s_d     = num_sides;
                        mask_d  = mask_calc;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = ST_DRAW;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (accept) begin
                    die_value_d = cand + SIDES_W'(1);
                    die_valid_d = 1'b1;
                    sum_d       = sum_q + SUM_W'(cand) + SUM_W'(1);
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == n_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRAW);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            roll_prev_q <= 1'b0;
            n_q         <= '0;
            s_q         <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            die_value_q <= '0;
            busy_q      <= 1'b0;
            die_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            roll_prev_q <= roll_prev_d;
            n_q         <= n_d;
            s_q         <= s_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            die_value_q <= die_value_d;
            busy_q      <= busy_d;
            die_valid_q <= die_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy      = busy_q;
    assign die_valid = die_valid_q;
    assign die_value = die_value_q;
    assign sum       = sum_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
